// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame geometry and the
// parity helper used by both the transmitter and the receiver.
package uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rxState_t;

    // Parity bit that makes data XOR parity equal oddParity.
    function automatic logic calcParity(input logic [UART_DATA_BITS-1:0] data,
                                        input logic oddParity);
        return (^data) ^ oddParity;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter with a restart input and a strobe at the
// middle of each bit period.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic sys_clk,
    input  logic sys_rst_l,
    input  logic restart,
    output logic midStrobe
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] bitCount;

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            bitCount <= '0;
        end else if (restart) begin
            bitCount <= '0;
        end else if (bitCount == CW'(CLKS_PER_BIT - 1)) begin
            bitCount <= '0;
        end else begin
            bitCount <= bitCount + 1'b1;
        end
    end

    assign midStrobe = !restart && (bitCount == CW'(CLKS_PER_BIT / 2 - 1));

endmodule

// File: rtl/uart_rx_frame.sv
// Oversampling UART receiver: synchronises the line, validates start, parity
// and stop bits, and presents each good byte through a ready/read register.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_l,
    input  logic                      uart_dataH,
    input  logic                      rec_readH,
    output logic [UART_DATA_BITS-1:0] rec_dataH,
    output logic                      rec_readyH,
    output logic                      frame_errH,
    output logic                      parity_errH,
    output logic                      overrunH
);

    rxState_t                  state;
    rxState_t                  nextState;
    logic                      syncMeta;
    logic                      syncLine;
    logic [2:0]                sampleHist;
    logic                      majority;
    logic                      midStrobe;
    logic                      timerRestart;
    logic [2:0]                bitIdx;
    logic [UART_DATA_BITS-1:0] shiftReg;
    logic                      parityBit;
    logic                      parityOk;
    logic                      loadByte;
    logic                      frameErrSet;
    logic                      parityErrSet;

    // Synchroniser and sample history idle high so reset looks like an idle line.
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            syncMeta   <= 1'b1;
            syncLine   <= 1'b1;
            sampleHist <= 3'b111;
        end else begin
            syncMeta   <= uart_dataH;
            syncLine   <= syncMeta;
            sampleHist <= {sampleHist[1:0], syncLine};
        end
    end

    assign majority = (sampleHist[0] & sampleHist[1]) |
                      (sampleHist[0] & sampleHist[2]) |
                      (sampleHist[1] & sampleHist[2]);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) bitTimer (
        .sys_clk  (sys_clk),
        .sys_rst_l(sys_rst_l),
        .restart  (timerRestart),
        .midStrobe(midStrobe)
    );

    assign parityOk = !PARITY_EN || (parityBit == calcParity(shiftReg, PARITY_ODD));

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState    = state;
        timerRestart = 1'b0;
        loadByte     = 1'b0;
        frameErrSet  = 1'b0;
        parityErrSet = 1'b0;
        case (state)
            IDLE: begin
                if (!syncLine) begin
                    nextState    = START;
                    timerRestart = 1'b1;
                end
            end
            START: begin
                if (midStrobe) begin
                    nextState = majority ? IDLE : DATA;
                end
            end
            DATA: begin
                if (midStrobe && bitIdx == 3'(UART_DATA_BITS - 1)) begin
                    nextState = PARITY_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (midStrobe) begin
                    nextState = STOP;
                end
            end
            STOP: begin
                // A low stop bit wins over a parity error and parks us until the line recovers.
                if (midStrobe) begin
                    if (!majority) begin
                        frameErrSet = 1'b1;
                        nextState   = BREAK;
                    end else if (!parityOk) begin
                        parityErrSet = 1'b1;
                        nextState    = IDLE;
                    end else begin
                        loadByte  = 1'b1;
                        nextState = IDLE;
                    end
                end
            end
            BREAK: begin
                if (majority) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            bitIdx    <= '0;
            shiftReg  <= '0;
            parityBit <= 1'b0;
        end else if (midStrobe) begin
            if (state == START) begin
                bitIdx <= '0;
            end
            if (state == DATA) begin
                shiftReg[bitIdx] <= majority;
                bitIdx           <= bitIdx + 1'b1;
            end
            if (state == PARITY) begin
                parityBit <= majority;
            end
        end
    end

    // A read on the load cycle consumes the old byte, so the new one is not an overrun.
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            rec_dataH   <= '0;
            rec_readyH  <= 1'b0;
            overrunH    <= 1'b0;
            frame_errH  <= 1'b0;
            parity_errH <= 1'b0;
        end else begin
            frame_errH  <= frameErrSet;
            parity_errH <= parityErrSet;
            if (loadByte) begin
                rec_dataH  <= shiftReg;
                rec_readyH <= 1'b1;
                overrunH   <= rec_readH ? 1'b0 : (overrunH | rec_readyH);
            end else if (rec_readH) begin
                rec_readyH <= 1'b0;
                overrunH   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Randomised bench for uart_rx_frame: an 8N1 and an 8E1 receiver are driven with
// serial frames and compared each cycle against a frame-level outcome model.
module tb_uart_rx_frame;

    localparam int EV_GOOD   = 0;
    localparam int EV_FRAME  = 1;
    localparam int EV_PARITY = 2;
    localparam int W_READY = 0, W_DATA = 1, W_OVR = 2, W_FERR = 3, W_PERR = 4;

    typedef struct {
        longint     due;
        int         d;
        int         kind;
        logic [7:0] data;
    } ev_t;

    typedef struct {
        longint     at;
        int         d;
        int         what;
        logic [7:0] val;
    } pin_t;

    logic            sysClk = 1'b0;
    logic [1:0]      rstL;
    logic [1:0]      line;
    logic [1:0]      readH;
    logic [1:0][7:0] recData;
    logic [1:0]      ready;
    logic [1:0]      frameErr;
    logic [1:0]      parityErr;
    logic [1:0]      overrun;

    ev_t    evArr[512];
    int     evCount = 0;
    int     evNext = 0;
    pin_t   pinArr[64];
    int     pinCount = 0;
    int     pinNext = 0;
    longint cycle = 0;
    int     checks = 0;
    int     errors = 0;

    logic [1:0][7:0] mData = '0;
    logic [1:0]      mReady = '0;
    logic [1:0]      mOver = '0;
    logic [1:0]      mFerr = '0;
    logic [1:0]      mPerr = '0;

    always #5 sysClk = ~sysClk;

    uart_rx_frame #(.CLKS_PER_BIT(16), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dutPlain (
        .sys_clk(sysClk), .sys_rst_l(rstL[0]), .uart_dataH(line[0]), .rec_readH(readH[0]),
        .rec_dataH(recData[0]), .rec_readyH(ready[0]), .frame_errH(frameErr[0]),
        .parity_errH(parityErr[0]), .overrunH(overrun[0])
    );

    uart_rx_frame #(.CLKS_PER_BIT(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dutParity (
        .sys_clk(sysClk), .sys_rst_l(rstL[1]), .uart_dataH(line[1]), .rec_readH(readH[1]),
        .rec_dataH(recData[1]), .rec_readyH(ready[1]), .frame_errH(frameErr[1]),
        .parity_errH(parityErr[1]), .overrunH(overrun[1])
    );

    // Frame outcomes land 155 edges after the pin falls (8N1), 16 more with a parity bit.
    always @(posedge sysClk) begin : refModel
        int idx;
        logic [1:0] ld, fe, pe;
        logic [1:0][7:0] nd;
        idx = evNext;
        ld  = '0;
        fe  = '0;
        pe  = '0;
        nd  = mData;
        while (idx < evCount && evArr[idx].due <= cycle + 1) begin
            if (evArr[idx].due == cycle + 1) begin
                case (evArr[idx].kind)
                    EV_GOOD:  begin ld[evArr[idx].d] = 1'b1; nd[evArr[idx].d] = evArr[idx].data; end
                    EV_FRAME: fe[evArr[idx].d] = 1'b1;
                    default:  pe[evArr[idx].d] = 1'b1;
                endcase
            end
            idx++;
        end
        evNext <= idx;
        for (int d = 0; d < 2; d++) begin
            if (!rstL[d]) begin
                mData[d] <= '0; mReady[d] <= 1'b0; mOver[d] <= 1'b0;
                mFerr[d] <= 1'b0; mPerr[d] <= 1'b0;
            end else begin
                mFerr[d] <= fe[d];
                mPerr[d] <= pe[d];
                if (ld[d]) begin
                    mData[d]  <= nd[d];
                    mReady[d] <= 1'b1;
                    mOver[d]  <= !readH[d] && (mOver[d] || mReady[d]);
                end else if (readH[d]) begin
                    mReady[d] <= 1'b0;
                    mOver[d]  <= 1'b0;
                end
            end
        end
        cycle <= cycle + 1;
    end

    task automatic checkOutput(input string name, input int d, input logic [7:0] act,
                               input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("[TB] FAIL %s dut%0d: got %h, expected %h (cycle %0d)",
                         name, d, act, exp, cycle);
        end
    endtask

    function automatic logic [7:0] outSel(input int d, input int what);
        case (what)
            W_READY: return {7'b0, ready[d]};
            W_DATA:  return recData[d];
            W_OVR:   return {7'b0, overrun[d]};
            W_FERR:  return {7'b0, frameErr[d]};
            default: return {7'b0, parityErr[d]};
        endcase
    endfunction

    always @(negedge sysClk) begin : compareProc
        int idx;
        for (int d = 0; d < 2; d++) begin
            if (!rstL[d]) begin
                checkOutput("resetData", d, recData[d], 8'h00);
                checkOutput("resetReady", d, {7'b0, ready[d]}, 8'h00);
                checkOutput("resetOverrun", d, {7'b0, overrun[d]}, 8'h00);
                checkOutput("resetFrameErr", d, {7'b0, frameErr[d]}, 8'h00);
                checkOutput("resetParityErr", d, {7'b0, parityErr[d]}, 8'h00);
            end else begin
                checkOutput("recData", d, recData[d], mData[d]);
                checkOutput("recReady", d, {7'b0, ready[d]}, {7'b0, mReady[d]});
                checkOutput("overrun", d, {7'b0, overrun[d]}, {7'b0, mOver[d]});
                checkOutput("frameErr", d, {7'b0, frameErr[d]}, {7'b0, mFerr[d]});
                checkOutput("parityErr", d, {7'b0, parityErr[d]}, {7'b0, mPerr[d]});
            end
        end
        idx = pinNext;
        while (idx < pinCount && pinArr[idx].at <= cycle) begin
            if (pinArr[idx].at == cycle)
                checkOutput($sformatf("literal%0d_w%0d", idx, pinArr[idx].what), pinArr[idx].d,
                            outSel(pinArr[idx].d, pinArr[idx].what), pinArr[idx].val);
            idx++;
        end
        pinNext = idx;
    end

    task automatic tick();
        @(posedge sysClk);
        #1;
    endtask

    task automatic addPin(input longint at, input int d, input int what, input logic [7:0] val);
        pinArr[pinCount] = '{at: at, d: d, what: what, val: val};
        pinCount++;
    endtask

    // Drives one frame starting now; bit k occupies pin cycles [round(k*b), round((k+1)*b)).
    task automatic applyStimulus(input int d, input logic [7:0] data, input logic stopBit,
                                 input logic parBad, input real skew, input int resetAt,
                                 input int readAt, input bit randRead);
        longint     start;
        int         nBits;
        int         total;
        int         k;
        real        b;
        logic [10:0] bits;
        start = cycle;
        nBits = (d == 1) ? 11 : 10;
        b     = 16.0 * skew;
        total = $rtoi(nBits * b + 0.5);
        bits  = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = data[i];
        if (d == 1) bits[9] = (^data) ^ parBad;
        bits[nBits-1] = stopBit;
        if (resetAt < 0) begin
            evArr[evCount].due  = start + 155 + ((d == 1) ? 16 : 0);
            evArr[evCount].d    = d;
            evArr[evCount].kind = !stopBit ? EV_FRAME : ((d == 1 && parBad) ? EV_PARITY : EV_GOOD);
            evArr[evCount].data = data;
            evCount++;
        end
        for (int j = 0; j < total; j++) begin
            k = 0;
            while (k < nBits - 1 && j >= $rtoi((k + 1) * b + 0.5)) k++;
            line[d] = bits[k];
            if (j == resetAt) rstL[d] = 1'b0;
            if (resetAt >= 0 && j == resetAt + 3) rstL[d] = 1'b1;
            if (j == readAt) readH[d] = 1'b1;
            else if (randRead) readH[d] = ($urandom_range(0, 5) == 0);
            else readH[d] = 1'b0;
            tick();
        end
        line[d]  = 1'b1;
        readH[d] = 1'b0;
    endtask

    task automatic readPulse(input int d);
        readH[d] = 1'b1;
        tick();
        readH[d] = 1'b0;
        tick();
    endtask

    initial begin
        longint s;
        int     d;
        logic   stopBit;
        logic   parBad;
        rstL  = 2'b00;
        line  = 2'b11;
        readH = 2'b00;
        repeat (5) tick();
        rstL = 2'b11;
        repeat (10) tick();

        // Clean 0xA5: ready rises exactly 155 edges after the pin falls.
        s = cycle;
        addPin(s + 154, 0, W_READY, 8'h00);
        addPin(s + 155, 0, W_READY, 8'h01);
        addPin(s + 155, 0, W_DATA, 8'hA5);
        addPin(s + 155, 0, W_FERR, 8'h00);
        applyStimulus(0, 8'hA5, 1'b1, 1'b0, 1.0, -1, -1, 1'b0);
        repeat (5) tick();
        readPulse(0);

        // Four-cycle glitch on an idle line.
        line[0] = 1'b0;
        repeat (4) tick();
        line[0] = 1'b1;
        addPin(cycle + 30, 0, W_READY, 8'h00);
        addPin(cycle + 30, 0, W_DATA, 8'hA5);
        repeat (40) tick();

        // Framing error then recovery.
        s = cycle;
        addPin(s + 155, 0, W_FERR, 8'h01);
        addPin(s + 155, 0, W_DATA, 8'hA5);
        addPin(s + 156, 0, W_FERR, 8'h00);
        applyStimulus(0, 8'h3C, 1'b0, 1'b0, 1.0, -1, -1, 1'b0);
        repeat (30) tick();
        s = cycle;
        addPin(s + 155, 0, W_DATA, 8'h55);
        addPin(s + 155, 0, W_READY, 8'h01);
        applyStimulus(0, 8'h55, 1'b1, 1'b0, 1.0, -1, -1, 1'b0);
        repeat (5) tick();
        readPulse(0);

        // Even parity: 0x07 needs parity bit 1.
        s = cycle;
        addPin(s + 171, 1, W_PERR, 8'h01);
        addPin(s + 171, 1, W_READY, 8'h00);
        applyStimulus(1, 8'h07, 1'b1, 1'b1, 1.0, -1, -1, 1'b0);
        repeat (10) tick();
        s = cycle;
        addPin(s + 171, 1, W_READY, 8'h01);
        addPin(s + 171, 1, W_DATA, 8'h07);
        addPin(s + 171, 1, W_PERR, 8'h00);
        applyStimulus(1, 8'h07, 1'b1, 1'b0, 1.0, -1, -1, 1'b0);
        repeat (5) tick();
        readPulse(1);

        // Overrun, then a read landing on the load cycle.
        applyStimulus(0, 8'h11, 1'b1, 1'b0, 1.0, -1, -1, 1'b0);
        s = cycle;
        addPin(s + 155, 0, W_DATA, 8'h22);
        addPin(s + 155, 0, W_OVR, 8'h01);
        applyStimulus(0, 8'h22, 1'b1, 1'b0, 1.0, -1, -1, 1'b0);
        repeat (3) tick();
        readPulse(0);
        addPin(cycle + 1, 0, W_OVR, 8'h00);
        addPin(cycle + 1, 0, W_READY, 8'h00);
        repeat (5) tick();
        applyStimulus(0, 8'h33, 1'b1, 1'b0, 1.0, -1, -1, 1'b0);
        s = cycle;
        addPin(s + 155, 0, W_DATA, 8'h44);
        addPin(s + 155, 0, W_READY, 8'h01);
        addPin(s + 155, 0, W_OVR, 8'h00);
        applyStimulus(0, 8'h44, 1'b1, 1'b0, 1.0, -1, 154, 1'b0);
        repeat (5) tick();

        // Reset during data bit 4 of 0xF0, then 0x81 nominal and skewed.
        applyStimulus(0, 8'hF0, 1'b1, 1'b0, 1.0, 88, -1, 1'b0);
        repeat (20) tick();
        s = cycle;
        addPin(s + 155, 0, W_DATA, 8'h81);
        applyStimulus(0, 8'h81, 1'b1, 1'b0, 1.0, -1, -1, 1'b0);
        readPulse(0);
        applyStimulus(0, 8'h81, 1'b1, 1'b0, 1.03, -1, -1, 1'b1);
        applyStimulus(0, 8'h81, 1'b1, 1'b0, 0.97, -1, -1, 1'b1);
        repeat (20) tick();

        // Randomised frames on both receivers.
        for (int n = 0; n < 40; n++) begin
            d       = $urandom_range(0, 1);
            stopBit = ($urandom_range(0, 7) != 0);
            parBad  = (d == 1) && ($urandom_range(0, 5) == 0);
            applyStimulus(d, 8'($urandom), stopBit, parBad,
                          0.97 + 0.0006 * $urandom_range(0, 100), -1, -1, 1'b1);
            if (!stopBit) repeat (25) tick();
            else repeat ($urandom_range(0, 20)) tick();
        end
        repeat (50) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
